// File: rtl/heichips25_pwm_bank.sv
// heichips25_pwm_bank: multi-channel PWM tile with shadowed duty registers,
// a shared prescaler, edge/center counting and per-channel enable/polarity.
// Ports:
//   clk, rst_n (async active-low)
//   ena        - tile power-good, unused
//   ui_in      - [7] WE, [6] RE, [3:0] register address
//   uio_in     - write data
//   uo_out     - registered PWM outputs
//   uio_out    - registered read data
//   uio_oe     - all ones while a read is active
module heichips25_pwm_bank #(
   parameter int CHANNELS = 8,
   parameter int WIDTH    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_duty   [CHANNELS];
   logic [WIDTH-1:0] r_active [CHANNELS];
   logic [7:0]       r_presc;
   logic [7:0]       r_enmask;
   logic [7:0]       r_pol;
   logic [1:0]       r_ctrl;
   logic [7:0]       r_pre;
   logic [WIDTH-1:0] r_cnt;
   logic             r_dir;
   logic             r_we_prev;

   logic             w_re;
   logic [3:0]       w_addr;
   logic             w_wr;
   logic             w_gen;
   logic             w_mode;
   logic             w_restart;
   logic             w_tick;
   logic [7:0]       w_pre_nxt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_dir_nxt;
   logic             w_load;
   logic [7:0]       w_rdata;
   logic [7:0]       w_pwm;
   logic             w_unused;

   assign w_re     = ui_in[6];
   assign w_addr   = ui_in[3:0];
   // one write per rising strobe; a concurrent read blocks it
   assign w_wr     = ui_in[7] & ~r_we_prev & ~w_re;
   assign w_gen    = r_ctrl[0];
   assign w_mode   = r_ctrl[1];
   assign w_tick   = (r_pre == r_presc);
   assign w_unused = &{1'b0, ena, ui_in[5:4]};

   // restart on a CTRL write that flips MODE or turns GEN on
   assign w_restart = w_wr && (w_addr == 4'd10) &&
                      ((uio_in[1] != w_mode) ||
                       (uio_in[0] && !w_gen));

   // register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < CHANNELS; n++)
            r_duty[n] <= '0;
         r_presc  <= '0;
         r_enmask <= '0;
         r_ctrl   <= '0;
         r_pol    <= '0;
      end else if (w_wr) begin
         for (int n = 0; n < CHANNELS; n++)
            if (w_addr == 4'(n))
               r_duty[n] <= uio_in[WIDTH-1:0];
         case (w_addr)
            4'd8:    r_presc  <= uio_in;
            4'd9:    r_enmask <= uio_in;
            4'd10:   r_ctrl   <= uio_in[1:0];
            4'd11:   r_pol    <= uio_in;
            default: ;
         endcase
      end
   end

   // prescaler / counter next state; w_load marks a period start
   always_comb begin
      w_pre_nxt = r_pre;
      w_cnt_nxt = r_cnt;
      w_dir_nxt = r_dir;
      w_load    = 1'b0;
      if (!w_gen || w_restart) begin
         w_pre_nxt = '0;
         w_cnt_nxt = '0;
         w_dir_nxt = 1'b0;
         w_load    = 1'b1;
      end else if (w_tick) begin
         w_pre_nxt = '0;
         if (!w_mode) begin
            if (r_cnt == MAX) begin
               w_cnt_nxt = '0;
               w_load    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end else if (!r_dir) begin
            if (r_cnt == MAX) begin
               w_cnt_nxt = MAX - ONE;
               w_dir_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end else begin
            w_cnt_nxt = r_cnt - ONE;
            if (r_cnt == ONE) begin
               w_dir_nxt = 1'b0;
               w_load    = 1'b1;
            end
         end
      end else begin
         w_pre_nxt = r_pre + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
         r_cnt <= '0;
         r_dir <= 1'b0;
         for (int n = 0; n < CHANNELS; n++)
            r_active[n] <= '0;
      end else begin
         r_pre <= w_pre_nxt;
         r_cnt <= w_cnt_nxt;
         r_dir <= w_dir_nxt;
         // shadow sampled before any same-edge duty write lands
         if (w_load)
            for (int n = 0; n < CHANNELS; n++)
               r_active[n] <= r_duty[n];
      end
   end

   // read mux, zero-extended
   always_comb begin
      w_rdata = '0;
      for (int n = 0; n < CHANNELS; n++)
         if (w_addr == 4'(n))
            w_rdata[WIDTH-1:0] = r_duty[n];
      case (w_addr)
         4'd8:    w_rdata = r_presc;
         4'd9:    w_rdata = r_enmask;
         4'd10:   w_rdata = {6'b0, r_ctrl};
         4'd11:   w_rdata = r_pol;
         default: ;
      endcase
   end

   always_comb begin
      w_pwm = '0;
      for (int n = 0; n < CHANNELS; n++)
         w_pwm[n] = ((r_cnt < r_active[n]) & r_enmask[n] & w_gen)
                    ^ r_pol[n];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we_prev <= 1'b0;
         uo_out    <= '0;
         uio_out   <= '0;
         uio_oe    <= '0;
      end else begin
         r_we_prev <= ui_in[7];
         uo_out    <= w_pwm;
         uio_oe    <= {8{w_re}};
         uio_out   <= w_re ? w_rdata : 8'h00;
      end
   end

endmodule

// File: tb/tb_heichips25_pwm_bank.sv
// Testbench for heichips25_pwm_bank: directed register-port stimulus,
// a tick-count based reference model and hand-computed waveform checks.
module tb_heichips25_pwm_bank;

   localparam int CH  = 8;
   localparam int MAX = 255;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = '0;
   logic [7:0] uio_in = '0;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_chk = 0;
   int n_fail = 0;

   heichips25_pwm_bank #(.CHANNELS(CH), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Counter position derived from ticks elapsed since the last restart.
   logic [7:0] m_reg [16];
   int         m_act [CH];
   int         m_e;
   bit         m_weprev;
   logic [7:0] m_uo, m_out, m_oe;

   function automatic int cnt_of(input int t, input bit mode);
      int p;
      if (!mode) return t % (MAX + 1);
      p = t % (2 * MAX);
      return (p <= MAX) ? p : 2 * MAX - p;
   endfunction

   always @(posedge clk or negedge rst_n) begin : mdl
      bit gen, mode, we, rs;
      int P, cnt, a;
      logic [7:0] nu;
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_reg[i] = '0;
         for (int i = 0; i < CH; i++) m_act[i] = 0;
         m_e = 0; m_weprev = 0;
         m_uo = '0; m_out = '0; m_oe = '0;
      end else begin
         gen  = m_reg[10][0];
         mode = m_reg[10][1];
         P    = m_reg[8];
         cnt  = cnt_of(m_e / (P + 1), mode);
         a    = ui_in[3:0];
         nu   = '0;
         for (int i = 0; i < CH; i++)
            nu[i] = ((cnt < m_act[i]) && m_reg[9][i] && gen) ^ m_reg[11][i];
         m_oe  = {8{ui_in[6]}};
         m_out = ui_in[6] ? m_reg[a] : 8'h00;
         we = ui_in[7] && !m_weprev && !ui_in[6];
         rs = we && a == 10 &&
              ((uio_in[1] != mode) || (uio_in[0] && !gen));
         if (!gen || rs) begin
            m_e = 0;
            for (int i = 0; i < CH; i++) m_act[i] = m_reg[i];
         end else begin
            m_e++;
            if (m_e % (P + 1) == 0 && cnt_of(m_e / (P + 1), mode) == 0)
               for (int i = 0; i < CH; i++) m_act[i] = m_reg[i];
         end
         if (we) begin
            if (a < CH || a == 8 || a == 9 || a == 11) m_reg[a] = uio_in;
            else if (a == 10) m_reg[a] = {6'b0, uio_in[1:0]};
         end
         m_weprev = ui_in[7];
         m_uo = nu;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("uo_out", uo_out, m_uo);
         check("uio_out", uio_out, m_out);
         check("uio_oe", uio_oe, m_oe);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      ui_in = {2'b10, 2'b00, a};
      uio_in = d;
      @(negedge clk);
      ui_in = '0;
      uio_in = '0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d,
                     output logic [7:0] oe);
      @(negedge clk);
      ui_in = {2'b01, 2'b00, a};
      @(negedge clk);
      d = uio_out;
      oe = uio_oe;
      ui_in = '0;
   endtask

   // wait for a 0->1 edge on uo_out[0]; returns 1 if seen
   task automatic wait_rise(input int lim, output bit ok);
      logic p;
      ok = 0;
      @(negedge clk);
      p = uo_out[0];
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (!p && uo_out[0]) begin
            ok = 1;
            break;
         end
         p = uo_out[0];
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] d, oe;
      int hi, hi2, oth, lo, per, fall;
      bit ok;
      logic p;

      // reset state
      #12;
      check("rst_uo", uo_out, 0);
      check("rst_uio_out", uio_out, 0);
      check("rst_uio_oe", uio_oe, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // edge mode, 64/256
      wr(8, 0); wr(0, 64); wr(9, 8'h01); wr(10, 8'h01);
      repeat (3) @(negedge clk);
      hi = 0; oth = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         hi += uo_out[0];
         if (uo_out[7:1] != 0) oth++;
      end
      check("edge_high", hi, 64);
      check("edge_others_zero", oth, 0);

      // extremes and polarity
      wr(1, 0); wr(2, 255); wr(11, 8'h02); wr(9, 8'h06);
      repeat (300) @(negedge clk);
      hi = 0; lo = 0; oth = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         hi += uo_out[1];
         lo += !uo_out[2];
         oth += uo_out[0];
      end
      check("duty0_inv_const1", hi, 256);
      check("dutymax_low1", lo, 1);
      check("disabled_ch0", oth, 0);

      // shadowing: duty change mid-period
      wr(11, 0); wr(9, 8'h01);
      wait_rise(600, ok);
      check("shadow_sync", ok, 1);
      hi = 1;
      for (int i = 1; i < 256; i++) begin
         @(negedge clk);
         if (i == 100) begin
            ui_in = 8'h80; uio_in = 8'd192;
         end else if (i == 101) begin
            ui_in = 8'h00; uio_in = 8'h00;
         end
         hi += uo_out[0];
      end
      hi2 = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         hi2 += uo_out[0];
      end
      check("shadow_cur_period", hi, 64);
      check("shadow_next_period", hi2, 192);

      // center mode with prescaler
      wr(10, 0); wr(8, 1); wr(0, 100); wr(10, 8'h03);
      wait_rise(2000, ok);
      check("center_sync", ok, 1);
      hi = 1; per = 1; fall = 0; ok = 0;
      p = 1'b1;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (!p && uo_out[0]) begin
            ok = 1;
            break;
         end
         if (p && !uo_out[0]) fall++;
         per++;
         hi += uo_out[0];
         p = uo_out[0];
      end
      check("center_rise2", ok, 1);
      check("center_period", per, 1020);
      check("center_high", hi, 398);
      check("center_one_pulse", fall, 1);

      // register port
      wr(10, 0);
      wr(8, 8'h5A);
      rd(8, d, oe);
      check("rd_presc", d, 8'h5A);
      check("rd_oe", oe, 8'hFF);
      rd(13, d, oe);
      check("rd_addr13", d, 0);
      wr(12, 8'h77);
      rd(12, d, oe);
      check("rd_addr12", d, 0);
      rd(0, d, oe);
      check("rd_duty0", d, 100);
      @(negedge clk);
      ui_in = {2'b10, 2'b00, 4'd11};
      uio_in = 8'h11;
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         uio_in = 8'(k * 8'h11);
      end
      @(negedge clk);
      ui_in = '0; uio_in = '0;
      rd(11, d, oe);
      check("we_held_once", d, 8'h11);
      @(negedge clk);
      ui_in = {2'b11, 2'b00, 4'd9};
      uio_in = 8'hEE;
      @(negedge clk);
      ui_in = '0; uio_in = '0;
      rd(9, d, oe);
      check("we_blocked_by_re", d, 8'h01);
      rd(10, d, oe);
      check("rd_ctrl", d, 0);

      // reset mid-operation
      wr(11, 0); wr(8, 0); wr(0, 64); wr(9, 8'h01); wr(10, 8'h01);
      @(negedge clk);
      ui_in = {2'b01, 2'b00, 4'd8};
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (uo_out[0]) begin
            ok = 1;
            break;
         end
      end
      check("pre_rst_high", ok, 1);
      check("pre_rst_oe", uio_oe, 8'hFF);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_uo", uo_out, 0);
      check("async_rst_uio_out", uio_out, 0);
      check("async_rst_uio_oe", uio_oe, 0);
      ui_in = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         rd(4'(a), d, oe);
         check("post_rst_rd", d, 0);
      end
      repeat (20) @(negedge clk);
      check("post_rst_uo", uo_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
